// File: rtl/sb_spi_host_pkg.sv
// Shared constants and state encoding for the SB_SPI bus-master sequencer.
// Register addresses are the low nibble of the system-bus address of the hard IP.
package sb_spi_pkg;

  localparam logic [3:0] REG_CR0  = 4'h8;
  localparam logic [3:0] REG_CR1  = 4'h9;
  localparam logic [3:0] REG_CR2  = 4'hA;
  localparam logic [3:0] REG_BR   = 4'hB;
  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;
  localparam logic [3:0] REG_CSR  = 4'hF;

  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;

  localparam logic [7:0] CR0_INIT = 8'h00;
  localparam logic [7:0] CR1_INIT = 8'h80;
  localparam logic [7:0] CR2_INIT = 8'hC0;
  localparam logic [7:0] CSR_IDLE = 8'h0F;

  typedef enum logic [3:0] {
    ST_INIT_CR0,
    ST_INIT_CR1,
    ST_INIT_CR2,
    ST_INIT_BR,
    ST_INIT_CSR,
    ST_IDLE,
    ST_CS_ON,
    ST_POLL_T,
    ST_WR_TX,
    ST_POLL_R,
    ST_RD_RX,
    ST_NEXT,
    ST_CS_OFF,
    ST_ERR
  } state_t;

  function automatic logic [7:0] reg_addr(input logic [3:0] hi, input logic [3:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/sb_spi_host_if.sv
// Byte-stream handshake plus SB_SPI system-bus signals of the host.
// master = the sequencer; slave = the environment (upstream logic and the hard IP).
interface sb_spi_host_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sb_rw;
  logic       sb_stb;
  logic [7:0] sb_adr;
  logic [7:0] sb_wdat;
  logic [7:0] sb_rdat;
  logic       sb_ack;
  logic       busy;
  logic       error;

  modport master (
    input  tx_data, tx_valid, tx_last, sb_rdat, sb_ack,
    output tx_ready, rx_data, rx_valid, sb_rw, sb_stb, sb_adr, sb_wdat, busy, error
  );

  modport slave (
    output tx_data, tx_valid, tx_last, sb_rdat, sb_ack,
    input  tx_ready, rx_data, rx_valid, sb_rw, sb_stb, sb_adr, sb_wdat, busy, error
  );
endinterface

// File: rtl/sb_spi_host_bus_access.sv
// Single strobe/ack transaction on the SB_SPI system bus with an ack timeout.
// done/timeout/rdata are valid on the edge that ends the strobe, so callers act on that same edge.
module sb_bus_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_wdat,
  input  logic [7:0] sb_rdat,
  input  logic       sb_ack
);

  localparam int CW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

  logic [CW-1:0] wait_cnt_reg;
  logic          stb_reg;
  logic          rw_reg;
  logic [7:0]    adr_reg;
  logic [7:0]    wdat_reg;

  // An ack on the expiry cycle wins over the timeout.
  assign done    = stb_reg & sb_ack;
  assign timeout = stb_reg & ~sb_ack & (wait_cnt_reg == CW'(ACK_TIMEOUT - 1));
  assign rdata   = sb_rdat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_reg      <= 1'b0;
      rw_reg       <= 1'b0;
      adr_reg      <= 8'h00;
      wdat_reg     <= 8'h00;
      wait_cnt_reg <= '0;
    end else if (stb_reg) begin
      if (done || timeout) begin
        stb_reg <= 1'b0;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end else if (start) begin
      stb_reg      <= 1'b1;
      rw_reg       <= rw;
      adr_reg      <= addr;
      wdat_reg     <= wdata;
      wait_cnt_reg <= '0;
    end
  end

  assign sb_stb  = stb_reg;
  assign sb_rw   = rw_reg;
  assign sb_adr  = adr_reg;
  assign sb_wdat = wdat_reg;

endmodule

// File: rtl/sb_spi_host.sv
// Configures the iCE40 SB_SPI hard IP as master and runs one polled full-duplex
// transfer per TX byte, holding chip select across a frame until tx_last.
module sb_spi_host #(
  parameter logic [3:0] BUS_ADDR74  = 4'b0000,
  parameter logic [7:0] SPI_BR      = 8'd7,
  parameter logic [3:0] CS_MASK     = 4'b1110,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  sb_spi_host_if.master bus
);
  import sb_spi_pkg::*;

  state_t     state_reg, state_next;
  logic       issued_reg;
  logic [7:0] data_reg;
  logic       last_reg;
  logic       tx_ready_reg;
  logic       busy_reg;
  logic       error_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;

  logic       acc_en, acc_rw, acc_start, acc_done, acc_timeout;
  logic [3:0] acc_lo;
  logic [7:0] acc_wdat, acc_rdata;
  logic       accept;

  // Each access state issues exactly one strobe per visit; polling re-issues after each done.
  assign acc_start = acc_en & ~issued_reg;

  sb_bus_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_access (
    .clk     (clk),
    .rst     (reset),
    .start   (acc_start),
    .rw      (acc_rw),
    .addr    (reg_addr(BUS_ADDR74, acc_lo)),
    .wdata   (acc_wdat),
    .done    (acc_done),
    .timeout (acc_timeout),
    .rdata   (acc_rdata),
    .sb_stb  (bus.sb_stb),
    .sb_rw   (bus.sb_rw),
    .sb_adr  (bus.sb_adr),
    .sb_wdat (bus.sb_wdat),
    .sb_rdat (bus.sb_rdat),
    .sb_ack  (bus.sb_ack)
  );

  always_comb begin
    state_next = state_reg;
    acc_en     = 1'b0;
    acc_rw     = 1'b0;
    acc_lo     = REG_SR;
    acc_wdat   = 8'h00;
    accept     = 1'b0;
    case (state_reg)
      ST_INIT_CR0: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_CR0; acc_wdat = CR0_INIT;
        if (acc_done) state_next = ST_INIT_CR1;
      end
      ST_INIT_CR1: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_CR1; acc_wdat = CR1_INIT;
        if (acc_done) state_next = ST_INIT_CR2;
      end
      ST_INIT_CR2: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_CR2; acc_wdat = CR2_INIT;
        if (acc_done) state_next = ST_INIT_BR;
      end
      ST_INIT_BR: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_BR; acc_wdat = SPI_BR;
        if (acc_done) state_next = ST_INIT_CSR;
      end
      ST_INIT_CSR: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_CSR; acc_wdat = CSR_IDLE;
        if (acc_done) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        accept = bus.tx_valid & tx_ready_reg;
        if (accept) state_next = ST_CS_ON;
      end
      ST_CS_ON: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_CSR; acc_wdat = {4'h0, CS_MASK};
        if (acc_done) state_next = ST_POLL_T;
      end
      ST_POLL_T: begin
        acc_en = 1'b1; acc_lo = REG_SR;
        if (acc_done && acc_rdata[SR_TRDY]) state_next = ST_WR_TX;
      end
      ST_WR_TX: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_TXDR; acc_wdat = data_reg;
        if (acc_done) state_next = ST_POLL_R;
      end
      ST_POLL_R: begin
        acc_en = 1'b1; acc_lo = REG_SR;
        if (acc_done && acc_rdata[SR_RRDY]) state_next = ST_RD_RX;
      end
      ST_RD_RX: begin
        acc_en = 1'b1; acc_lo = REG_RXDR;
        if (acc_done) state_next = last_reg ? ST_CS_OFF : ST_NEXT;
      end
      ST_NEXT: begin
        accept = bus.tx_valid & tx_ready_reg;
        if (accept) state_next = ST_POLL_T;
      end
      ST_CS_OFF: begin
        acc_en = 1'b1; acc_rw = 1'b1; acc_lo = REG_CSR; acc_wdat = CSR_IDLE;
        if (acc_done) state_next = ST_IDLE;
      end
      default: state_next = ST_ERR;
    endcase
    if (acc_timeout) state_next = ST_ERR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_INIT_CR0;
      issued_reg   <= 1'b0;
      data_reg     <= 8'h00;
      last_reg     <= 1'b0;
      tx_ready_reg <= 1'b0;
      busy_reg     <= 1'b1;
      error_reg    <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (acc_done || acc_timeout) begin
        issued_reg <= 1'b0;
      end else if (acc_start) begin
        issued_reg <= 1'b1;
      end
      if (accept) begin
        data_reg <= bus.tx_data;
        last_reg <= bus.tx_last;
      end
      // Status outputs follow the state being entered so they are registered yet not late.
      tx_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_NEXT);
      busy_reg     <= !((state_next == ST_IDLE) || (state_next == ST_NEXT) || (state_next == ST_ERR));
      error_reg    <= error_reg | acc_timeout;
      rx_valid_reg <= (state_reg == ST_RD_RX) && acc_done;
      if ((state_reg == ST_RD_RX) && acc_done) begin
        rx_data_reg <= acc_rdata;
      end
    end
  end

  assign bus.tx_ready = tx_ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.error    = error_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;

endmodule
